// File: rtl/uart_pkg.sv
// Shared types and constants for the UART response transmitter.
// Frame states, ASCII terminators and the default oversample ratio.
package uart_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } tx_state_t;

   localparam logic [7:0] ASCII_CR = 8'h0D;
   localparam logic [7:0] ASCII_LF = 8'h0A;

   localparam int OVERSAMPLE_DEF = 16;

endpackage

// File: rtl/uart_tx_shifter.sv
// 8N1 serializer: start bit, 8 data bits LSB first, stop bit.
// frame_end pulses for one clk after the stop bit completes.
module uart_tx_shifter
   import uart_pkg::*;
#(
   parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       clken,
   input  logic       start,
   input  logic [7:0] data,
   output logic       txd,
   output logic       busy,
   output logic       frame_end
);

   localparam logic [3:0] TICK_LAST = 4'(OVERSAMPLE - 1);

   tx_state_t  state;
   tx_state_t  state_n;
   logic [3:0] tick_cnt;
   logic [2:0] bit_idx;
   logic [7:0] shreg;
   logic       bit_end;

   assign bit_end = clken && (tick_cnt == TICK_LAST);
   assign busy    = (state != IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_n;
      end
   end

   always_comb begin
      state_n = state;
      txd     = 1'b1;
      unique case (state)
         IDLE: begin
            if (start) state_n = START;
         end
         START: begin
            txd = 1'b0;
            if (bit_end) state_n = DATA;
         end
         DATA: begin
            txd = shreg[0];
            if (bit_end && bit_idx == 3'd7) state_n = STOP;
         end
         STOP: begin
            if (bit_end) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   // Counters are held clear in IDLE so every frame starts fresh
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tick_cnt  <= '0;
         bit_idx   <= '0;
         shreg     <= '0;
         frame_end <= 1'b0;
      end else begin
         frame_end <= (state == STOP) && bit_end;
         if (state == IDLE) begin
            tick_cnt <= '0;
            bit_idx  <= '0;
            if (start) shreg <= data;
         end else if (clken) begin
            tick_cnt <= bit_end ? 4'd0 : tick_cnt + 4'd1;
            if (state == DATA && bit_end) begin
               shreg   <= {1'b0, shreg[7:1]};
               bit_idx <= bit_idx + 3'd1;
            end
         end
      end
   end

endmodule

// File: rtl/uart_response_tx.sv
// Response transmitter: request handshake with re-arm, optional
// CR/LF trailer after each message, framing done by uart_tx_shifter.
module uart_response_tx
   import uart_pkg::*;
#(
   parameter int APPEND_CRLF = 1,
   parameter int OVERSAMPLE  = OVERSAMPLE_DEF
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       clken_16bps,
   input  logic [7:0] tx_data,
   input  logic       tx_req,
   input  logic       resp_active,
   output logic       txd,
   output logic       tx_done,
   output logic       tx_busy
);

   logic       sh_busy;
   logic       frame_end;
   logic       start;
   logic [7:0] sh_data;
   logic       armed;
   logic       crlf_pending;
   logic       lf_pending;
   logic       resp_d;
   logic       cur_req;
   logic       idle;
   logic       fall;
   logic       take_lf;
   logic       take_cr;
   logic       take_req;

   assign idle = ~sh_busy;
   assign fall = (APPEND_CRLF != 0) && resp_d && !resp_active;

   // LF finishes a started trailer, then a new trailer beats a request
   assign take_lf  = idle & lf_pending;
   assign take_cr  = idle & ~lf_pending & crlf_pending;
   assign take_req = idle & ~lf_pending & ~crlf_pending
                   & tx_req & armed;
   assign start    = take_lf | take_cr | take_req;

   always_comb begin
      sh_data = tx_data;
      if (take_lf) begin
         sh_data = ASCII_LF;
      end else if (take_cr) begin
         sh_data = ASCII_CR;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         armed        <= 1'b1;
         crlf_pending <= 1'b0;
         lf_pending   <= 1'b0;
         resp_d       <= 1'b0;
         cur_req      <= 1'b0;
      end else begin
         resp_d <= resp_active;
         if (take_req) begin
            armed <= 1'b0;
         end else if (!tx_req) begin
            armed <= 1'b1;
         end
         if (fall) begin
            crlf_pending <= 1'b1;
         end else if (take_cr) begin
            crlf_pending <= 1'b0;
         end
         if (take_cr) begin
            lf_pending <= 1'b1;
         end else if (take_lf) begin
            lf_pending <= 1'b0;
         end
         if (start) cur_req <= take_req;
      end
   end

   assign tx_done = frame_end & cur_req;
   assign tx_busy = sh_busy | crlf_pending | lf_pending;

   uart_tx_shifter #(
      .OVERSAMPLE(OVERSAMPLE)
   ) u_shifter (
      .clk      (clk),
      .rst_n    (rst_n),
      .clken    (clken_16bps),
      .start    (start),
      .data     (sh_data),
      .txd      (txd),
      .busy     (sh_busy),
      .frame_end(frame_end)
   );

endmodule

// File: doc/uart_response_tx.md
UART_RESPONSE_TX -- requirements
Module: uart_response_tx

Interface
REQ-001 The block SHALL have parameter APPEND_CRLF, default 1, meaning: 1 appends 0x0D 0x0A after each response message, 0 disables this.
REQ-002 The block SHALL have parameter OVERSAMPLE, default 16, meaning: clken_16bps ticks per UART bit.
REQ-003 clk  input  1  system clock.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 clken_16bps  input  1  single-cycle enable at 16x baud rate.
REQ-006 tx_data  input  8  byte to send, from parser response_data.
REQ-007 tx_req  input  1  byte-valid level, from parser response_flag.
REQ-008 resp_active  input  1  message-in-progress level, from parser response_ready.
REQ-009 txd  output  1  UART serial line, 8N1, idle high.
REQ-010 tx_done  output  1  one-clk pulse when a requested byte's stop bit completes.
REQ-011 tx_busy  output  1  high while any frame (requested or CR/LF) is in flight or pending.

Function
REQ-012 The frame SHALL be 1 start bit (0), 8 data bits LSB first, 1 stop bit (1), with each bit lasting exactly OVERSAMPLE clken_16bps ticks.
REQ-013 The FSM SHALL have states IDLE, START, DATA, STOP; the bit-tick counter SHALL be 4 bits wrapping 15->0 and advance only on clken_16bps.
REQ-014 A request SHALL be accepted in IDLE when tx_req=1 and armed=1; tx_data is latched and txd drives 0 from the next clk.
REQ-015 After acceptance, armed SHALL clear and SHALL set again only after tx_req is sampled 0, so a held tx_req never resends the same byte.
REQ-016 Transitions: START->DATA after 16 ticks; DATA->STOP after the 8th bit's 16 ticks (bit index 0..7, 3 bits); STOP->IDLE after 16 ticks.
REQ-017 On STOP->IDLE for a requested byte, tx_done SHALL pulse high for exactly one clk; it SHALL NOT pulse for CR/LF frames.
REQ-018 With APPEND_CRLF=1, a 1->0 edge on resp_active SHALL set a crlf_pending flag; the flag is taken once in IDLE and sends 0x0D then 0x0A back-to-back.
REQ-019 When crlf_pending and an armed tx_req are both ready in IDLE in the same cycle, crlf_pending SHALL win, and the request SHALL wait.
REQ-020 A resp_active falling edge while a frame is in flight SHALL be remembered and served after that frame; a second edge before service SHALL NOT queue a second CR/LF.
REQ-021 tx_busy SHALL equal (state!=IDLE) OR crlf_pending OR the LF-still-to-send flag.
REQ-022 tx_req changes mid-frame SHALL be ignored; tx_data SHALL be sampled only at acceptance.
REQ-023 Back-to-back: the next accepted frame's start bit SHALL begin no earlier than the clk after STOP->IDLE (minimum idle of 0 bit periods between frames).

Reset
REQ-024 On rst_n=0 the block SHALL immediately set txd=1, tx_done=0, tx_busy=0, state=IDLE, armed=1, crlf_pending=0, and clear all counters, mid-frame included.
REQ-025 After release, the first accepted request SHALL produce a complete, correctly timed frame; no partial frame SHALL resume.

Structure
REQ-026 Package uart_pkg SHALL hold the state encoding, ASCII_CR=8'h0D, ASCII_LF=8'h0A, and the default OVERSAMPLE value.
REQ-027 The block SHALL use one sub-module, uart_tx_shifter (start/shift/stop serializer with a frame_end pulse); the top level SHALL hold the handshake, armed, and CR/LF logic.

Verification
REQ-028 Drive tx_data=0x41 with tx_req held until tx_done -> txd sequence 0,1,0,0,0,0,0,1,0,1, each 16 ticks; one tx_done pulse; no resend.
REQ-029 Drive the parser-style message "cmd_invalid" (11 bytes) then resp_active 1->0 -> 13 frames, ending 0x0D,0x0A; exactly 11 tx_done pulses.
REQ-030 With APPEND_CRLF=0 and the same message -> 11 frames only; tx_busy low after the last stop bit.
REQ-031 Drop resp_active during the 5th bit of a frame, with tx_req armed in the same cycle the frame ends -> CR/LF sent first, then the request.
REQ-032 Assert rst_n=0 during bit 3 of 0x55 -> txd=1 the same cycle; after release, 0xAA is sent with correct framing.
REQ-033 Toggle tx_req 1->0->1 within one frame -> second byte accepted only after the first frame ends, with tx_done pulses 2.
